// File: rtl/aibcr3_red_pkg.sv
// aibcr3_red_pkg: sequencer state/request enums and the index-to-thermometer helper
package aibcr3_red_pkg;
  localparam int MAX_LANES = 256;
  typedef enum logic [2:0] {IDLE, GATE, SWITCH, SETTLE, DONE} state_t;
  typedef enum logic {RED, JTAG} pend_t;
  function automatic logic [MAX_LANES-1:0] idx_to_therm(input int idx, input int n);
    logic [MAX_LANES-1:0] t;
    for (int i = 0; i < MAX_LANES; i++) t[i] = (i >= idx) && (i < n);
    return t;
  endfunction
endpackage

// File: rtl/aibcr3_red_therm_dec.sv
// aibcr3_red_therm_dec: failing-lane index to per-lane shift thermometer (bit i set when i >= idx)
module aibcr3_red_therm_dec
  import aibcr3_red_pkg::*;
#(
  parameter int NUM_LANES = 24,
  parameter int IDX_W = $clog2(NUM_LANES + 1)
) (
  input  logic [IDX_W-1:0]     idx,
  output logic [NUM_LANES-1:0] therm
);
  // idx == NUM_LANES yields all-zero (no repair)
  always_comb therm = NUM_LANES'(idx_to_therm(int'(idx), NUM_LANES));
endmodule

// File: rtl/aibcr3_red_shift_seq.sv
// aibcr3_red_shift_seq: glitch-safe sequencer for lane shift_en and JTAG clock select (optional AIBCR3_RED_SWITCH_CNT_EN adds red_cnt)
module aibcr3_red_shift_seq
  import aibcr3_red_pkg::*;
#(
  parameter int NUM_LANES = 24,
  parameter int GATE_CYC = 4,
  parameter int IDX_W = $clog2(NUM_LANES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 red_req,
  input  logic [IDX_W-1:0]     red_idx,
  input  logic                 jtag_clksel,
  output logic [NUM_LANES-1:0] shift_en,
  output logic                 jtag_clksel_q,
  output logic                 clk_en,
  output logic                 busy,
  output logic                 red_ack,
  output logic                 err_idx,
  output logic                 err_ovf
`ifdef AIBCR3_RED_SWITCH_CNT_EN
  ,
  output logic [7:0]           red_cnt
`endif
);
  localparam int CNT_W = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  state_t state, state_d;
  pend_t pend_type, pend_type_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] pend_idx, pend_idx_d;
  logic pend_sel, pend_sel_d, err_pend, idx_bad, cnt_last;
  logic [NUM_LANES-1:0] therm;
  assign idx_bad = red_idx > IDX_W'(NUM_LANES);
  assign cnt_last = cnt == CNT_W'(GATE_CYC - 1);
  assign busy = state != IDLE;
  aibcr3_red_therm_dec #(.NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) u_dec (.idx(pend_idx), .therm(therm));
  // next-state: accept work in IDLE (repair first), then gate, switch, settle, done
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    pend_idx_d = pend_idx;
    pend_type_d = pend_type;
    pend_sel_d = pend_sel;
    case (state)
      IDLE:
        if (red_req && !idx_bad) begin
          state_d = GATE;
          pend_idx_d = red_idx;
          pend_type_d = RED;
        end else if (!red_req && jtag_clksel != jtag_clksel_q) begin
          state_d = GATE;
          pend_sel_d = jtag_clksel;
          pend_type_d = JTAG;
        end
      GATE, SETTLE: begin
        cnt_d = cnt_last ? '0 : cnt + 1'b1;
        state_d = !cnt_last ? state : (state == GATE ? SWITCH : DONE);
      end
      SWITCH: state_d = SETTLE;
      default: state_d = IDLE;
    endcase
  end
  // sequencer state and latched pending request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      pend_idx <= '0;
      pend_type <= RED;
      pend_sel <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      pend_idx <= pend_idx_d;
      pend_type <= pend_type_d;
      pend_sel <= pend_sel_d;
    end
  // registered outputs, each derived from the current state so muxes only move while clk_en is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shift_en <= '0;
      jtag_clksel_q <= 1'b0;
      clk_en <= 1'b1;
      red_ack <= 1'b0;
      err_idx <= 1'b0;
      err_ovf <= 1'b0;
      err_pend <= 1'b0;
`ifdef AIBCR3_RED_SWITCH_CNT_EN
      red_cnt <= '0;
`endif
    end else begin
      clk_en <= state == IDLE || state == DONE;
      err_pend <= state == IDLE && red_req && idx_bad;
      red_ack <= (state == DONE && pend_type == RED) || err_pend;
      err_idx <= err_idx || err_pend;
      err_ovf <= err_ovf || (busy && red_req);
      shift_en <= (state == SWITCH && pend_type == RED) ? therm : shift_en;
      jtag_clksel_q <= (state == SWITCH && pend_type == JTAG) ? pend_sel : jtag_clksel_q;
`ifdef AIBCR3_RED_SWITCH_CNT_EN
      red_cnt <= (state == DONE && red_cnt != 8'hFF) ? red_cnt + 8'd1 : red_cnt;
`endif
    end
endmodule

// File: tb/tb_aibcr3_red_shift_seq.sv
// tb_aibcr3_red_shift_seq: scoreboarded directed and random checks of the redundancy shift sequencer
module tb_aibcr3_red_shift_seq;
  localparam int N = 24;
  localparam int G = 4;
  localparam int IW = $clog2(N + 1);
  typedef struct {int cyc; logic [N-1:0] shift; logic err;} exp_t;
  logic clk = 0, rst_n = 1, red_req = 0, jtag_clksel = 0;
  logic [IW-1:0] red_idx = '0;
  logic [N-1:0] shift_en;
  logic jtag_clksel_q, clk_en, busy, red_ack, err_idx, err_ovf;
`ifdef AIBCR3_RED_SWITCH_CNT_EN
  logic [7:0] red_cnt;
`endif
  int cyc = 0, errors = 0, checks = 0;
  exp_t q[$];
  logic [N-1:0] m_shift = '0;
  logic m_err = 0, m_ovf = 0;

  aibcr3_red_shift_seq #(.NUM_LANES(N), .GATE_CYC(G)) dut (
    .clk(clk), .rst_n(rst_n), .red_req(red_req), .red_idx(red_idx), .jtag_clksel(jtag_clksel),
    .shift_en(shift_en), .jtag_clksel_q(jtag_clksel_q), .clk_en(clk_en), .busy(busy),
    .red_ack(red_ack), .err_idx(err_idx), .err_ovf(err_ovf)
`ifdef AIBCR3_RED_SWITCH_CNT_EN
    , .red_cnt(red_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] ref_therm(input int idx);
    logic [63:0] all = (64'd1 << N) - 64'd1;
    return N'(all & ~((64'd1 << idx) - 64'd1));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic req(input int idx, input logic jt, output int e);
    @(negedge clk);
    red_req = 1;
    red_idx = IW'(idx);
    jtag_clksel = jt;
    e = cyc + 1;
    if (idx > N) begin
      m_err = 1;
      q.push_back('{e + 1, m_shift, 1'b1});
    end else begin
      m_shift = ref_therm(idx);
      q.push_back('{e + 2 * G + 2, m_shift, m_err});
    end
    @(negedge clk);
    red_req = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    for (int t = 0; t < 300 && n < 3; t++) begin
      @(negedge clk);
      n = busy ? 0 : n + 1;
    end
    checks++;
    if (n < 3) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b expected 0", busy);
    end
  endtask

  // ack monitor: every red_ack must match the oldest outstanding expectation
  always @(negedge clk)
    if (rst_n && red_ack) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack at cycle %0d, expected none", cyc);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("ack_cycle", 64'(cyc), 64'(x.cyc));
        chk("ack_shift_en", 64'(shift_en), 64'(x.shift));
        chk("ack_err_idx", 64'(err_idx), 64'(x.err));
      end
    end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int e, idx, r;
    logic jt;
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_shift_en", 64'(shift_en), 0);
    chk("rst_jtag_q", 64'(jtag_clksel_q), 0);
    chk("rst_clk_en", 64'(clk_en), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ack", 64'(red_ack), 0);
    chk("rst_err_idx", 64'(err_idx), 0);
    chk("rst_err_ovf", 64'(err_ovf), 0);
    rst_n = 1;
    // idx 5: cycle-accurate gating window
    req(5, 0, e);
    chk("clk_en_k0", 64'(clk_en), 1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk($sformatf("clk_en_k%0d", k), 64'(clk_en), 64'(k > 9));
      if (k == 2) chk("busy_gate", 64'(busy), 1);
      if (k == 4) chk("shift_before", 64'(shift_en), 0);
      if (k == 5) chk("shift_after", 64'(shift_en), 64'h00FFFFE0);
    end
    wait_idle();
    // boundary indices
    req(24, 0, e);
    wait_idle();
    chk("shift_none", 64'(shift_en), 0);
    req(0, 0, e);
    wait_idle();
    chk("shift_all", 64'(shift_en), 64'h00FFFFFF);
    // out-of-range index
    req(25, 0, e);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("bad_clk_en", 64'(clk_en), 1);
      chk("bad_busy", 64'(busy), 0);
    end
    chk("err_idx_set", 64'(err_idx), 1);
    chk("bad_shift_kept", 64'(shift_en), 64'h00FFFFFF);
    // repair and JTAG change together: repair first, JTAG after
    req(7, 1, e);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 12) chk("jtag_gated", 64'(clk_en), 0);
      if (k == 15) chk("jtag_q_before", 64'(jtag_clksel_q), 0);
      if (k == 16) chk("jtag_q_after", 64'(jtag_clksel_q), 1);
    end
    wait_idle();
    // overflow during GATE
    req(9, 1, e);
    @(negedge clk);
    @(negedge clk);
    chk("ovf_clear", 64'(err_ovf), 0);
    red_req = 1;
    red_idx = IW'(2);
    @(negedge clk);
    red_req = 0;
    chk("err_ovf_set", 64'(err_ovf), 1);
    wait_idle();
    chk("ovf_shift", 64'(shift_en), 64'(ref_therm(9)));
    // async reset during SETTLE
    req(3, 0, e);
    repeat (6) @(negedge clk);
    chk("pre_rst_shift", 64'(shift_en), 64'(ref_therm(3)));
    @(negedge clk);
    chk("settle_busy", 64'(busy), 1);
    chk("settle_clk_en", 64'(clk_en), 0);
    rst_n = 0;
    q.delete();
    m_shift = '0;
    m_err = 0;
    #1;
    chk("arst_shift_en", 64'(shift_en), 0);
    chk("arst_jtag_q", 64'(jtag_clksel_q), 0);
    chk("arst_clk_en", 64'(clk_en), 1);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_err_idx", 64'(err_idx), 0);
    chk("arst_err_ovf", 64'(err_ovf), 0);
    @(negedge clk);
    rst_n = 1;
    req(11, 0, e);
    wait_idle();
    chk("post_rst_shift", 64'(shift_en), 64'(ref_therm(11)));
    // randomized requests with occasional JTAG changes and overflow attempts
    for (int i = 0; i < 30; i++) begin
      idx = int'($urandom_range(0, N + 2));
      jt = ($urandom_range(0, 3) == 0) ? ~jtag_clksel : jtag_clksel;
      req(idx, jt, e);
      if (idx <= N && $urandom_range(0, 3) == 0) begin
        r = int'($urandom_range(1, 8));
        repeat (r) @(negedge clk);
        red_req = 1;
        red_idx = IW'($urandom_range(0, N));
        @(negedge clk);
        red_req = 0;
        m_ovf = 1;
      end
      wait_idle();
      chk("rand_shift", 64'(shift_en), 64'(m_shift));
      chk("rand_jtag_q", 64'(jtag_clksel_q), 64'(jtag_clksel));
      chk("rand_err_ovf", 64'(err_ovf), 64'(m_ovf));
      chk("rand_err_idx", 64'(err_idx), 64'(m_err));
    end
    repeat (5) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_ack: %0d acks pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
